// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU-side VIC-II register bus initiator:
//   - cpu_bus_state_t : transaction state (IDLE, ARM, DRIVE, RESP)
//   - *_K localparams : phi-high cycle indices at which the bus strobes change
//   - in_window()     : half-open window test on a phase index
// -----------------------------------------------------------------------------
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DRIVE = 2'd2,
    RESP  = 2'd3
  } cpu_bus_state_t;

  // Phase indices k within phi-high; k = 0 is the phi rising-edge cycle.
  localparam logic [3:0] CE_ASSERT_K  = 4'd3;   // first cycle with ce low
  localparam logic [3:0] CE_RELEASE_K = 4'd15;  // first cycle with ce high again
  localparam logic [3:0] DB_DRIVE_K   = 4'd4;   // first cycle driving dbl on writes
  localparam logic [3:0] RD_SAMPLE_K  = 4'd13;  // dbl_i captured at the end of this cycle

  // True when lo <= k < hi.
  function automatic logic in_window(input logic [3:0] k,
                                     input logic [3:0] lo,
                                     input logic [3:0] hi);
    return (k >= lo) && (k < hi);
  endfunction

endpackage

// File: rtl/phi_phase_counter.sv
// -----------------------------------------------------------------------------
// phi_phase_counter
// Tracks where the current clk_dot4x cycle sits inside the phi-high phase.
// Ports:
//   clk_dot4x : system clock (clk_phi is synchronous to it)
//   rst_n     : asynchronous active-low reset
//   clk_phi   : CPU phi clock
//   rise      : 1 in the first phi-high cycle (clk_phi & ~phi_d)
//   k         : phi-high cycle index, 0 at rise, saturating at the last
//               phi-high index, 0 while phi is low
// -----------------------------------------------------------------------------
module phi_phase_counter #(
  parameter int PHI_HIGH_CYCLES = 16
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic       clk_phi,
  output logic       rise,
  output logic [3:0] k
);

  localparam logic [3:0] K_LAST = 4'(PHI_HIGH_CYCLES - 1);

  logic       phi_d;
  logic [3:0] k_reg;

  // phi_d resets high so that leaving reset in the middle of phi-high does
  // not fabricate a rising edge; the first usable edge is a genuine one.
  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      phi_d <= 1'b1;
      k_reg <= 4'd0;
    end else begin
      phi_d <= clk_phi;
      if (!clk_phi) begin
        k_reg <= 4'd0;
      end else if (k_reg != K_LAST) begin
        k_reg <= k_reg + 4'd1;
      end
    end
  end

  assign rise = clk_phi & ~phi_d;
  // k_reg is already 0 in the rise cycle because the previous cycle was phi low.
  assign k    = clk_phi ? k_reg : 4'd0;

endmodule

// File: rtl/cpu_bus_master.sv
// -----------------------------------------------------------------------------
// cpu_bus_master
// Single-outstanding register-bus initiator: accepts one read/write request,
// performs a 6510-style access in the next eligible phi-high phase and returns
// a one-cycle response at the start of phi-low.
// Ports:
//   clk_dot4x, rst_n        : system clock, asynchronous active-low reset
//   clk_phi                 : CPU phi clock (synchronous to clk_dot4x)
//   aec                     : 1 = CPU may own the bus (0 also aborts an access)
//   ba                      : 0 = reads must stall (writes still proceed)
//   req_valid/req_ready     : request handshake (ready only when idle)
//   req_we/req_addr/req_wdata : request direction, register index, write data
//   rsp_valid/rsp_rdata     : completion pulse and read data (0 for writes)
//   ce, rw                  : chip enable (active low), 1 = read / 0 = write
//   adl_o/adl_oe            : address bus value and drive enable
//   dbl_o/dbl_oe/dbl_i      : data bus value, drive enable and sample
// -----------------------------------------------------------------------------
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int PHI_HIGH_CYCLES = 16
) (
  input  logic       clk_dot4x,
  input  logic       rst_n,
  input  logic       clk_phi,
  input  logic       aec,
  input  logic       ba,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       ce,
  output logic       rw,
  output logic [5:0] adl_o,
  output logic       adl_oe,
  output logic [7:0] dbl_o,
  output logic       dbl_oe,
  input  logic [7:0] dbl_i
);

  localparam logic [3:0] K_LAST = 4'(PHI_HIGH_CYCLES - 1);

  cpu_bus_state_t state_reg;
  logic           we_reg;
  logic [5:0]     addr_reg;
  logic [7:0]     wdata_reg;
  logic [7:0]     rdata_reg;

  logic           rise;
  logic [3:0]     k;
  logic [3:0]     k_next;

  phi_phase_counter #(
    .PHI_HIGH_CYCLES(PHI_HIGH_CYCLES)
  ) u_phase (
    .clk_dot4x(clk_dot4x),
    .rst_n    (rst_n),
    .clk_phi  (clk_phi),
    .rise     (rise),
    .k        (k)
  );

  // Strobes are registered, so the value computed in cycle k is seen in k+1.
  assign k_next    = k + 4'd1;
  assign req_ready = (state_reg == IDLE);

  always_ff @(posedge clk_dot4x or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= 6'd0;
      wdata_reg <= 8'd0;
      rdata_reg <= 8'd0;
      ce        <= 1'b1;
      rw        <= 1'b1;
      adl_o     <= 6'd0;
      adl_oe    <= 1'b0;
      dbl_o     <= 8'd0;
      dbl_oe    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            state_reg <= ARM;
          end
        end

        ARM: begin
          // Only a write may use a phase while the VIC holds ba low.
          if (rise && aec && (we_reg || ba)) begin
            state_reg <= DRIVE;
            adl_o     <= addr_reg;
            adl_oe    <= 1'b1;
            rw        <= ~we_reg;
            if (we_reg) begin
              dbl_o <= wdata_reg;
            end
          end
        end

        DRIVE: begin
          if (!aec || !clk_phi) begin
            // Lost the bus: let go of everything and retry the same request.
            state_reg <= ARM;
            ce        <= 1'b1;
            rw        <= 1'b1;
            adl_oe    <= 1'b0;
            dbl_oe    <= 1'b0;
          end else begin
            if (!we_reg && (k == RD_SAMPLE_K)) begin
              rdata_reg <= dbl_i;
            end
            if (k == K_LAST) begin
              // ce is already high here; address and data are released one
              // cycle later for turnaround.
              state_reg <= RESP;
              ce        <= 1'b1;
              rw        <= 1'b1;
              adl_oe    <= 1'b0;
              dbl_oe    <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_rdata <= we_reg ? 8'd0 : rdata_reg;
            end else begin
              ce     <= ~in_window(k_next, CE_ASSERT_K, CE_RELEASE_K);
              dbl_oe <= we_reg && (k_next >= DB_DRIVE_K);
            end
          end
        end

        RESP: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
module tb_cpu_bus_master;

  logic       clk_dot4x = 1'b0;
  logic       rst_n;
  logic       clk_phi;
  logic       aec;
  logic       ba;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       ce;
  logic       rw;
  logic [5:0] adl_o;
  logic       adl_oe;
  logic [7:0] dbl_o;
  logic       dbl_oe;
  logic [7:0] dbl_i;

  // Bench-owned phi: 32 dot4x cycles per period, high while phase_cnt < 16,
  // so the rise cycle is phase 0 and k equals phase_cnt during phi-high.
  logic [4:0] phase_cnt = 5'd20;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  // scratch for the directed/random sequence
  logic       t_we;
  logic [5:0] t_addr;
  logic [7:0] t_wdata;
  logic [7:0] t_rdval;
  int         t_drop;
  logic [5:0] b_addr [4];
  logic [7:0] b_wdata[4];
  int         b_idx, b_nrsp, b_last;

  always #5 clk_dot4x = ~clk_dot4x;

  always @(posedge clk_dot4x) begin
    phase_cnt <= phase_cnt + 5'd1;
    cyc       <= cyc + 1;
  end

  assign clk_phi = ~phase_cnt[4];

  cpu_bus_master #(.PHI_HIGH_CYCLES(16)) dut (
    .clk_dot4x(clk_dot4x),
    .rst_n    (rst_n),
    .clk_phi  (clk_phi),
    .aec      (aec),
    .ba       (ba),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .ce       (ce),
    .rw       (rw),
    .adl_o    (adl_o),
    .adl_oe   (adl_oe),
    .dbl_o    (dbl_o),
    .dbl_oe   (dbl_oe),
    .dbl_i    (dbl_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
      end
  endtask

  task automatic garbage_req();
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = 6'($urandom);
    req_wdata = 8'($urandom);
  endtask

  // Idle cycles: the bus must stay released and the master ready.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_dot4x);
      chk("idle.req_ready", req_ready, 1'b1);
      chk("idle.rsp_valid", rsp_valid, 1'b0);
      chk("idle.ce", ce, 1'b1);
      chk("idle.adl_oe", adl_oe, 1'b0);
      chk("idle.dbl_oe", dbl_oe, 1'b0);
      garbage_req();
      aec   = 1'($urandom_range(0, 1));
      ba    = 1'($urandom_range(0, 1));
      dbl_i = 8'($urandom);
    end
  endtask

  task automatic wait_phase(input logic [4:0] p);
    for (int i = 0; i < 40 && phase_cnt != p; i++) idle(1);
  endtask

  // One transaction against a window model: the access occupies the phi-high
  // phase that starts at the first eligible rise after the accept cycle, and
  // every strobe is a fixed function of the offset from that rise.
  //   ba_stall   : ba is 0 for this many rises after accept
  //   aec_drop_k : aec is 0 for one cycle at this k of the first attempt (<1: never)
  //   rst_k      : rst_n pulsed at this k of the first attempt (<0: never)
  task automatic run_txn(input string tag, input logic we, input logic [5:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdval,
                         input int ba_stall, input int aec_drop_k, input int rst_k);
    int acc, win, k, rise_idx, attempts;
    bit done, act;
    acc = -1; win = -1; rise_idx = 0; attempts = 0; done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk_dot4x);
      k   = (win >= 0) ? cyc - win : -1;
      act = (k >= 1 && k <= 15);
      chk({tag, ".req_ready"}, req_ready, acc < 0);
      chk({tag, ".ce"}, ce, !(act && k >= 3 && k <= 14));
      chk({tag, ".adl_oe"}, adl_oe, act);
      chk({tag, ".rw"}, rw, act ? !we : 1'b1);
      chk({tag, ".dbl_oe"}, dbl_oe, act && we && k >= 4);
      chk({tag, ".rsp_valid"}, rsp_valid, k == 16);
      if (act) chk({tag, ".adl_o"}, adl_o, addr);
      if (act && we && k >= 4) chk({tag, ".dbl_o"}, dbl_o, wdata);
      if (k == 16) begin
        chk({tag, ".rsp_rdata"}, rsp_rdata, we ? 8'h00 : rdval);
        $display("txn %s we=%0d addr=0x%02h wdata=0x%02h rdata=0x%02h latency=%0d retries=%0d",
                 tag, we, addr, wdata, rsp_rdata, cyc - acc, attempts);
        done = 1'b1;
      end
      // inputs for this cycle (sampled at the edge that ends it)
      if (acc < 0) begin
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        acc       = cyc;
      end else begin
        garbage_req();
      end
      if (acc != cyc && phase_cnt == 5'd0) rise_idx++;
      ba    = (rise_idx > ba_stall);
      aec   = !(attempts == 0 && aec_drop_k >= 1 && k == aec_drop_k);
      dbl_i = (!we && k == 13) ? rdval : rdval ^ 8'($urandom_range(1, 255));
      if (rst_k >= 0 && k == rst_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".rst_ce"}, ce, 1'b1);
        chk({tag, ".rst_adl_oe"}, adl_oe, 1'b0);
        chk({tag, ".rst_rw"}, rw, 1'b1);
        chk({tag, ".rst_dbl_oe"}, dbl_oe, 1'b0);
        chk({tag, ".rst_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, ".rst_req_ready"}, req_ready, 1'b1);
        @(negedge clk_dot4x);
        rst_n = 1'b1;
        garbage_req();
        $display("txn %s we=%0d addr=0x%02h reset at k=%0d, transaction dropped", tag, we, addr, k);
        done = 1'b1;
        idle(40);
      end else if (win >= 0 && act && !aec) begin
        win = -1;
        attempts++;
      end else if (win < 0 && acc != cyc && phase_cnt == 5'd0 && aec && (we || ba)) begin
        win = cyc;
      end
    end
    checks++;
    assert (done)
      else begin
        failures++;
        $error("FAIL %s.timeout observed=no response expected=response within 400 cycles", tag);
      end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 6'd0; req_wdata = 8'd0;
    aec = 1'b1; ba = 1'b1; dbl_i = 8'd0;
    repeat (3) @(negedge clk_dot4x);
    chk("reset.ce", ce, 1'b1);
    chk("reset.rw", rw, 1'b1);
    chk("reset.adl_oe", adl_oe, 1'b0);
    chk("reset.dbl_oe", dbl_oe, 1'b0);
    chk("reset.adl_o", adl_o, 6'd0);
    chk("reset.dbl_o", dbl_o, 8'd0);
    chk("reset.rsp_valid", rsp_valid, 1'b0);
    chk("reset.rsp_rdata", rsp_rdata, 8'd0);
    chk("reset.req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    idle(3);

    // directed steps from the plan
    run_txn("wr20", 1'b1, 6'h20, 8'h0E, 8'h00, 0, -1, -1);
    idle(5);
    run_txn("rd12", 1'b0, 6'h12, 8'h00, 8'h37, 0, -1, -1);
    wait_phase(5'd30);  // accept in the cycle before rise: shortest latency
    run_txn("best", 1'b1, 6'($urandom), 8'($urandom), 8'h00, 0, -1, -1);
    wait_phase(5'd31);  // accept in the rise cycle: must use the following rise
    run_txn("worst", 1'b0, 6'($urandom), 8'h00, 8'($urandom), 0, -1, -1);
    run_txn("rd_ba", 1'b0, 6'($urandom), 8'h00, 8'($urandom), 3, -1, -1);
    run_txn("wr_ba", 1'b1, 6'($urandom), 8'($urandom), 8'h00, 3, -1, -1);
    run_txn("wr_aec", 1'b1, 6'($urandom), 8'($urandom), 8'h00, 0, 8, -1);
    run_txn("rd_rst", 1'b0, 6'($urandom), 8'h00, 8'($urandom), 0, -1, 6);

    // back-to-back writes with req_valid held
    for (int i = 0; i < 4; i++) begin
      b_addr[i]  = 6'($urandom);
      b_wdata[i] = 8'($urandom);
    end
    b_idx = 0; b_nrsp = 0; b_last = -1;
    aec = 1'b1; ba = 1'b1;
    for (int n = 0; n < 400 && b_nrsp < 4; n++) begin
      @(negedge clk_dot4x);
      if (rsp_valid) begin
        if (b_last >= 0) chk("b2b.rsp_spacing", cyc - b_last, 32);
        chk("b2b.rsp_rdata", rsp_rdata, 8'h00);
        $display("txn b2b%0d we=1 addr=0x%02h wdata=0x%02h rsp_cycle=%0d",
                 b_nrsp, b_addr[b_nrsp], b_wdata[b_nrsp], cyc);
        b_last = cyc;
        b_nrsp++;
      end
      if (!ce && b_nrsp < 4) begin
        chk("b2b.adl_o", adl_o, b_addr[b_nrsp]);
        chk("b2b.rw", rw, 1'b0);
      end
      if (dbl_oe && b_nrsp < 4) chk("b2b.dbl_o", dbl_o, b_wdata[b_nrsp]);
      if (b_idx < 4) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = b_addr[b_idx];
        req_wdata = b_wdata[b_idx];
        if (req_ready) b_idx++;
      end else begin
        garbage_req();
      end
    end
    chk("b2b.accepts", b_idx, 4);
    chk("b2b.responses", b_nrsp, 4);

    // randomized transactions
    for (int t = 0; t < 12; t++) begin
      idle(int'($urandom_range(0, 40)));
      t_we    = 1'($urandom_range(0, 1));
      t_addr  = 6'($urandom);
      t_wdata = 8'($urandom);
      t_rdval = 8'($urandom);
      t_drop  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
      run_txn("rnd", t_we, t_addr, t_wdata, t_rdval, int'($urandom_range(0, 2)), t_drop, -1);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
